// File: rtl/inst_fetch.sv
// inst_fetch: RV32I fetch stage; holds the PC, issues word reads, queues returned instructions for decode.
// Latency: startSig at N -> read request at N+1 -> instValid at N+2 when the grant arrives at N+1.
// Backpressure: decode stalls via instReady=0; once the queue is full, reads stop (FULL) until a pop or a redirect.
//
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   startSig                              one-cycle start pulse (only honoured in IDLE)
//   fetchReadAddr/En/Fin/Data             storage read port (reader 0, low priority)
//   instValid/instData/instPc/instReady   instruction handshake to decode
//   redirectEn/redirectPc                 branch/jump redirect (flushes the queue)
//   fetchBusy                             high whenever the stage is not IDLE
//
// Build option: define INST_FETCH_PREFETCH_EN for a two-entry instruction queue;
// otherwise a single-entry holding register is used.

module inst_fetch #(
  parameter int          READ_ADDR_SIZE = 28,
  parameter int          ROW_WIDTH      = 32,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      startSig,
  output logic [READ_ADDR_SIZE-1:0] fetchReadAddr,
  output logic                      fetchReadEn,
  input  logic                      fetchReadFin,
  input  logic [ROW_WIDTH-1:0]      fetchReadData,
  output logic                      instValid,
  output logic [ROW_WIDTH-1:0]      instData,
  output logic [31:0]               instPc,
  input  logic                      instReady,
  input  logic                      redirectEn,
  input  logic [31:0]               redirectPc,
  output logic                      fetchBusy
);

`ifdef INST_FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

  state_t               state;
  logic [29:0]          pc_word;    // PC is always word aligned, so only bits [31:2] are stored
  logic [1:0]           count;
  logic [ROW_WIDTH-1:0] q_dat0, q_dat1;
  logic [31:0]          q_pc0, q_pc1;

  logic pop, push, queue_full;
  logic unused_bits;

  assign pop         = instValid & instReady;
  // A pop in the same cycle frees a slot, which is what lets the single-entry
  // build sustain one instruction per cycle.
  assign queue_full  = (count == 2'(DEPTH)) & ~pop;
  assign fetchReadEn = (state == RUN) & ~redirectEn & ~queue_full;
  assign push        = fetchReadEn & fetchReadFin;

  assign fetchReadAddr = pc_word[READ_ADDR_SIZE-1:0];
  assign instValid     = (count != 2'd0);
  assign instData      = q_dat0;
  assign instPc        = q_pc0;
  assign fetchBusy     = (state != IDLE);

  // The redirect target's byte-offset bits are ignored; PC word bits beyond the
  // storage address width are dropped from the read address, so the index wraps.
  assign unused_bits = ^{redirectPc[1:0], pc_word};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc_word <= RESET_PC[31:2];
      count   <= 2'd0;
      q_dat0  <= '0;
      q_dat1  <= '0;
      q_pc0   <= '0;
      q_pc1   <= '0;
    end else begin
      case (state)
        IDLE:    if (startSig) state <= RUN;
        RUN:     if (!redirectEn && queue_full) state <= FULL;
        FULL:    if (pop || redirectEn) state <= RUN;
        default: state <= IDLE;
      endcase

      if (redirectEn) begin
        pc_word <= redirectPc[31:2];
      end else if (push) begin
        pc_word <= pc_word + 30'd1;
      end

      // Head always lives in slot 0 so instData/instPc come straight from flops.
      if (redirectEn) begin
        count <= 2'd0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              q_dat0 <= fetchReadData;
              q_pc0  <= {pc_word, 2'b00};
            end else begin
              q_dat1 <= fetchReadData;
              q_pc1  <= {pc_word, 2'b00};
            end
            count <= count + 2'd1;
          end
          2'b01: begin
            q_dat0 <= q_dat1;
            q_pc0  <= q_pc1;
            count  <= count - 2'd1;
          end
          2'b11: begin
            if (count == 2'd1) begin
              q_dat0 <= fetchReadData;
              q_pc0  <= {pc_word, 2'b00};
            end else begin
              q_dat0 <= q_dat1;
              q_pc0  <= q_pc1;
              q_dat1 <= fetchReadData;
              q_pc1  <= {pc_word, 2'b00};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed stimulus with a scoreboard of expected
// (instData, instPc) pairs, popped by a monitor on every decode handshake.
// Latency: n/a. Backpressure: driven by the bench through instReady.

module tb_inst_fetch;

`ifdef INST_FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        startSig;
  logic [27:0] fetchReadAddr;
  logic        fetchReadEn;
  logic        fetchReadFin;
  logic [31:0] fetchReadData;
  logic        instValid;
  logic [31:0] instData;
  logic [31:0] instPc;
  logic        instReady;
  logic        redirectEn;
  logic [31:0] redirectPc;
  logic        fetchBusy;

  typedef struct {
    logic [31:0] dat;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [0:31];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  assign fetchReadData = mem[fetchReadAddr[4:0]];

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .startSig     (startSig),
    .fetchReadAddr(fetchReadAddr),
    .fetchReadEn  (fetchReadEn),
    .fetchReadFin (fetchReadFin),
    .fetchReadData(fetchReadData),
    .instValid    (instValid),
    .instData     (instData),
    .instPc       (instPc),
    .instReady    (instReady),
    .redirectEn   (redirectEn),
    .redirectPc   (redirectPc),
    .fetchBusy    (fetchBusy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_inst(input logic [31:0] dat, input logic [31:0] pc);
    exp_t e;
    e.dat = dat;
    e.pc  = pc;
    exp_q.push_back(e);
  endtask

  // Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    startSig     = 1'b0;
    fetchReadFin = 1'b0;
    redirectEn   = 1'b0;
    redirectPc   = 32'h0;
    instReady    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_pulse();
    startSig = 1'b1;
    tick();
    startSig = 1'b0;
  endtask

  // Monitor: every accepted instruction must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && instValid && instReady) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_inst: got pc %h data %h, none expected at %0t", instPc, instData, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pop_data", instData, e.dat);
        chk("pop_pc", instPc, e.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0000_0093;
    mem[2] = 32'h0000_0113;
    mem[3] = 32'h0000_0193;

    // T1: reset values, then streaming fetch at one instruction per cycle.
    do_reset();
    #1;
    chk("rst_valid", 32'(instValid), 32'd0);
    chk("rst_data", instData, 32'h0);
    chk("rst_pc", instPc, 32'h0);
    chk("rst_en", 32'(fetchReadEn), 32'd0);
    chk("rst_busy", 32'(fetchBusy), 32'd0);
    instReady = 1'b1;
    for (int i = 0; i < 4; i++) expect_inst(mem[i], 32'(4 * i));
    start_pulse();
    fetchReadFin = 1'b1;
    #1;
    chk("t1_busy", 32'(fetchBusy), 32'd1);
    chk("t1_en", 32'(fetchReadEn), 32'd1);
    chk("t1_addr", 32'(fetchReadAddr), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk("t1_stream_valid", 32'(instValid), 32'd1);
    end
    fetchReadFin = 1'b0;
    tick();
    tick();
    #1;
    chk("t1_drained", 32'(instValid), 32'd0);

    // T2: grant withheld for three cycles; address and PC hold.
    do_reset();
    instReady = 1'b1;
    start_pulse();
    #1;
    chk("t2_addr0", 32'(fetchReadAddr), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("t2_hold_addr", 32'(fetchReadAddr), 32'h0);
      chk("t2_hold_valid", 32'(instValid), 32'd0);
    end
    fetchReadFin = 1'b1;
    expect_inst(mem[0], 32'h0);
    tick();
    fetchReadFin = 1'b0;
    #1;
    chk("t2_valid", 32'(instValid), 32'd1);
    chk("t2_pc", instPc, 32'h0);
    tick();
    #1;
    chk("t2_empty", 32'(instValid), 32'd0);

    // T3: decode stalled; queue fills, reads stop, head stays stable, then drains in order.
    do_reset();
    start_pulse();
    fetchReadFin = 1'b1;
    for (int i = 0; i < DEPTH; i++) expect_inst(mem[i], 32'(4 * i));
    repeat (DEPTH + 1) tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3_full_en", 32'(fetchReadEn), 32'd0);
      chk("t3_head_valid", 32'(instValid), 32'd1);
      chk("t3_head_pc", instPc, 32'h0);
      chk("t3_head_data", instData, 32'h0000_0013);
      tick();
    end
    instReady    = 1'b1;
    fetchReadFin = 1'b0;
    repeat (DEPTH) tick();
    #1;
    chk("t3_drained", 32'(instValid), 32'd0);
    tick();
    #1;
    chk("t3_no_dup", 32'(instValid), 32'd0);

    // T4: redirect to 0x43 while the queue is occupied.
    do_reset();
    start_pulse();
    fetchReadFin = 1'b1;
    repeat (DEPTH + 1) tick();
    redirectEn = 1'b1;
    redirectPc = 32'h0000_0043;
    #1;
    chk("t4_redir_en", 32'(fetchReadEn), 32'd0);
    tick();
    redirectEn = 1'b0;
    #1;
    chk("t4_flush_valid", 32'(instValid), 32'd0);
    chk("t4_addr", 32'(fetchReadAddr), 32'h10);
    chk("t4_en", 32'(fetchReadEn), 32'd1);
    expect_inst(mem[16], 32'h40);
    instReady = 1'b1;
    tick();
    fetchReadFin = 1'b0;
    #1;
    chk("t4_new_pc", instPc, 32'h40);
    tick();
    #1;
    chk("t4_empty", 32'(instValid), 32'd0);

    // T5: redirect coincides with a grant and a pop; no push survives.
    do_reset();
    instReady = 1'b1;
    start_pulse();
    fetchReadFin = 1'b1;
    expect_inst(mem[0], 32'h0);
    tick();
    redirectEn = 1'b1;
    redirectPc = 32'h0000_0100;
    #1;
    chk("t5_valid_pre", 32'(instValid), 32'd1);
    chk("t5_en_suppr", 32'(fetchReadEn), 32'd0);
    tick();
    redirectEn   = 1'b0;
    fetchReadFin = 1'b0;
    #1;
    chk("t5_no_push", 32'(instValid), 32'd0);
    chk("t5_addr", 32'(fetchReadAddr), 32'h40);
    tick();
    #1;
    chk("t5_still_empty", 32'(instValid), 32'd0);

    // T6: reset mid-run with the queue occupied.
    do_reset();
    start_pulse();
    fetchReadFin = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_valid", 32'(instValid), 32'd0);
    chk("t6_busy", 32'(fetchBusy), 32'd0);
    chk("t6_en", 32'(fetchReadEn), 32'd0);
    chk("t6_pc", instPc, 32'h0);
    chk("t6_addr", 32'(fetchReadAddr), 32'h0);
    instReady = 1'b1;
    tick();
    tick();
    #1;
    chk("t6_idle_en", 32'(fetchReadEn), 32'd0);
    chk("t6_idle_valid", 32'(instValid), 32'd0);
    expect_inst(mem[0], 32'h0);
    start_pulse();
    #1;
    chk("t6_restart_en", 32'(fetchReadEn), 32'd1);
    chk("t6_restart_addr", 32'(fetchReadAddr), 32'h0);
    tick();
    fetchReadFin = 1'b0;
    tick();
    #1;
    chk("t6_done", 32'(instValid), 32'd0);

    // T7: redirect while IDLE to the top of the address space; PC wraps to 0.
    do_reset();
    instReady  = 1'b1;
    redirectEn = 1'b1;
    redirectPc = 32'hFFFF_FFFE;
    tick();
    redirectEn = 1'b0;
    #1;
    chk("t7_idle_busy", 32'(fetchBusy), 32'd0);
    chk("t7_idle_valid", 32'(instValid), 32'd0);
    chk("t7_idle_en", 32'(fetchReadEn), 32'd0);
    chk("t7_addr_top", 32'(fetchReadAddr), 32'h0FFF_FFFF);
    expect_inst(mem[31], 32'hFFFF_FFFC);
    expect_inst(mem[0], 32'h0);
    start_pulse();
    fetchReadFin = 1'b1;
    #1;
    chk("t7_en", 32'(fetchReadEn), 32'd1);
    tick();
    tick();
    fetchReadFin = 1'b0;
    #1;
    chk("t7_addr_wrap", 32'(fetchReadAddr), 32'h1);
    tick();
    tick();
    #1;
    chk("t7_empty", 32'(instValid), 32'd0);

    chk("exp_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the RV32I multicycle pipeline. It sits directly upstream of the shared storage block and drives one of that block's read ports (the low-priority reader 0). It holds the program counter, issues word reads, and buffers returned instructions. It hands them to decode through a valid/ready handshake and redirects on taken branches and jumps.

## Interface
- READ_ADDR_SIZE, 28: storage word-address width.
- ROW_WIDTH, 32: storage row width; instruction width.
- RESET_PC, 32'h0000_0000: PC loaded on reset.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- startSig  in  1  one-cycle pulse; leaves IDLE.
- fetchReadAddr  out  READ_ADDR_SIZE  word address = pc[READ_ADDR_SIZE+1:2].
- fetchReadEn  out  1  read request to storage.
- fetchReadFin  in  1  grant; data valid the same cycle.
- fetchReadData  in  ROW_WIDTH  combinational read data.
- instValid  out  1  queue head valid.
- instData  out  ROW_WIDTH  queue head instruction.
- instPc  out  32  byte PC of the queue head.
- instReady  in  1  decode accepts the head this cycle.
- redirectEn  in  1  branch or jump redirect.
- redirectPc  in  32  new byte PC; bits [1:0] are ignored and forced to 0.
- fetchBusy  out  1  state != IDLE.

## Operation
- States:
  - IDLE: after reset. Goes to RUN when startSig=1.
  - RUN: fetching.
  - FULL: queue full, no read issued. Goes to RUN on the cycle a pop occurs or redirectEn=1.
- fetchReadEn = (state==RUN) & ~redirectEn & ~queueFull. This is combinational; it is 0 in IDLE and FULL.
- A read completes when fetchReadEn & fetchReadFin. On completion, push {fetchReadData, pc} and set pc <= pc+4.
- Without fin (reader 1 has priority), hold fetchReadAddr and retry the next cycle. Do not increment pc.
- Pop when instValid & instReady.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- Redirect: pc <= {redirectPc[31:2],2'b00} and the queue is flushed (instValid=0 the next cycle). Any read in that cycle is suppressed, so no push occurs. Redirect overrides a simultaneous pop and push. A redirect in IDLE updates pc only.
- PC arithmetic is modulo 2^32. fetchReadAddr truncates the upper bits, so the storage index wraps.
- Occupancy is never above depth. A push on a full queue cannot occur because fetchReadEn is gated.
- startSig outside IDLE is ignored.

## Timing
- Reset values:
  - pc=RESET_PC
  - state=IDLE
  - instValid=0, instData=0, instPc=0
  - fetchReadEn=0, fetchBusy=0
  - queue empty
- rst has priority over every other input. Asserting rst mid-fetch discards queue contents and pc.
- Latency:
  - startSig at cycle N puts the block in RUN at N+1, with fetchReadEn=1 at N+1.
  - With fin at N+1, instValid=1 at N+2 carrying instPc=RESET_PC.
- Redirect at cycle N: fetchReadAddr reflects redirectPc at N+1. The first redirected instruction is valid at N+2 at the earliest.
- Sustained throughput is one instruction per cycle when fin is held high and instReady is held high.
- instData and instPc are registered queue outputs, stable while instValid=1 and instReady=0.

## Configuration
- INST_FETCH_PREFETCH_EN:
  - Defined: two-entry FIFO queue. Fetch continues while occupancy < 2, and FULL is entered at occupancy 2.
  - Undefined: single-entry register. FULL is entered as soon as one instruction is held and no pop happens the same cycle, so steady-state throughput with instReady held is still 1/cycle via push-with-pop.
  - All ports, reset values and redirect behaviour are identical in both builds.

## Test plan
- Reset then startSig; fin=1, instReady=1, mem[0..3]=0x13,0x93,0x113,0x193 -> instData sequence 0x13,0x93,0x113,0x193 on consecutive cycles from start+2, instPc 0,4,8,12.
- Hold fin=0 for 3 cycles after start -> fetchReadAddr stays 0 and instValid=0; fin=1 on the 4th cycle -> instValid with instPc=0 the next cycle.
- instReady=0 with fin=1 -> queue fills (1 entry, or 2 with INST_FETCH_PREFETCH_EN), fetchReadEn drops to 0, head is stable at instPc=0; raise instReady -> entries drain in order with no loss or duplication.
- redirectEn=1 with redirectPc=0x0000_0043 while the queue holds 0,4 -> next cycle instValid=0 and fetchReadAddr=0x10; the following instPc is 0x40.
- redirectEn asserted in the same cycle as fin and a pop -> no push, queue empty, pc=redirect target.
- rst asserted mid-run with queue occupied -> next cycle IDLE, instValid=0, pc=RESET_PC, fetchReadEn=0 until the next startSig.
